// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Port ids double as the round-robin history bit.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  localparam logic PORT_P  = 1'b0;
  localparam logic PORT_D  = 1'b1;
  localparam int   LAT_MAX = 7;
  localparam int   CNT_W   = 3;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin chooser: a lone requester wins, contention goes to
// the port that was not granted last.
module dmem_rr_pick
  import dmem_pkg::*;
(
  input  logic p_req,
  input  logic d_req,
  input  logic last_gnt,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = p_req | d_req;
    if (p_req & d_req) grant_id = ~last_gnt;
    else if (d_req)    grant_id = PORT_D;
    else               grant_id = PORT_P;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the pipeline (P) and the
// loader/debug port (D) with fixed-latency IDLE -> ACCESS -> RESP transactions.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       p_req,
  input  logic       p_we,
  input  logic [7:0] p_addr,
  input  logic [7:0] p_wdata,
  output logic       p_ack,
  output logic [7:0] p_rdata,
  output logic       stall,
  input  logic       d_req,
  input  logic       d_we,
  input  logic [7:0] d_addr,
  input  logic [7:0] d_wdata,
  output logic       d_ack,
  output logic [7:0] d_rdata,
  output logic       m_en,
  output logic       m_we,
  output logic [7:0] m_addr,
  output logic [7:0] m_wdata,
  input  logic [7:0] m_rdata
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_gnt_q;
  logic             gnt_q;
  logic             m_en_q, m_we_q;
  logic [7:0]       m_addr_q, m_wdata_q;
  logic             p_ack_q, d_ack_q;
  logic [7:0]       p_rdata_q, d_rdata_q;

  logic             grant_valid, grant_id;
  logic             sel_we_d;
  logic [7:0]       sel_addr_d, sel_wdata_d;

  dmem_rr_pick u_pick (
    .p_req       (p_req),
    .d_req       (d_req),
    .last_gnt    (last_gnt_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    sel_we_d    = p_we;
    sel_addr_d  = p_addr;
    sel_wdata_d = p_wdata;
    if (grant_id == PORT_D) begin
      sel_we_d    = d_we;
      sel_addr_d  = d_addr;
      sel_wdata_d = d_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      last_gnt_q <= PORT_D;
      gnt_q      <= PORT_P;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      p_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      p_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      p_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            gnt_q      <= grant_id;
            last_gnt_q <= grant_id;
            m_en_q     <= 1'b1;
            m_we_q     <= sel_we_d;
            m_addr_q   <= sel_addr_d;
            m_wdata_q  <= sel_wdata_d;
            cnt_q      <= CNT_LOAD;
            state_q    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            // Last access cycle: memory data is valid now, ack shows next cycle.
            m_en_q <= 1'b0;
            if (!m_we_q) begin
              if (gnt_q == PORT_P) p_rdata_q <= m_rdata;
              else                 d_rdata_q <= m_rdata;
            end
            if (gnt_q == PORT_P) p_ack_q <= 1'b1;
            else                 d_ack_q <= 1'b1;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign p_ack   = p_ack_q;
  assign d_ack   = d_ack_q;
  assign p_rdata = p_rdata_q;
  assign d_rdata = d_rdata_q;
  assign m_en    = m_en_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign stall   = p_req & ~p_ack_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-port 8-bit data memory. It shares the memory between the pipeline MEM stage (port P) and the loader/debug port (port D). Each access runs as a fixed-latency, multi-cycle transaction. While a pipeline access is outstanding, the block raises `stall` so the pipeline freezes.

## Interface
Parameters:
- `LAT`, default 1: memory access cycles per transaction; legal range 1..7.

Ports:
- `clock`  in  1: system clock; all state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `p_req`  in  1: pipeline access request.
- `p_we`  in  1: pipeline write enable (0 = read).
- `p_addr`  in  8: pipeline address.
- `p_wdata`  in  8: pipeline write data.
- `p_ack`  out  1: one-cycle pipeline completion pulse.
- `p_rdata`  out  8: pipeline read data; valid with `p_ack` on reads.
- `stall`  out  1: `p_req & ~p_ack`, combinational.
- `d_req`, `d_we`, `d_addr[7:0]`, `d_wdata[7:0]`  in: debug port request signals, same meaning as the P port.
- `d_ack`  out  1: debug port completion pulse, same meaning as `p_ack`.
- `d_rdata`  out  8: debug port read data, same meaning as `p_rdata`.
- `m_en`  out  1: memory enable.
- `m_we`  out  1: memory write enable.
- `m_addr`  out  8: memory address.
- `m_wdata`  out  8: memory write data.
- `m_rdata`  in  8: memory read data; valid in the last access cycle.

## Operation
- The FSM has three states: IDLE, ACCESS, RESP.
- **IDLE**
  - With no request pending, stay in IDLE.
  - With exactly one request pending, grant that port.
  - With both ports requesting, grant the port not granted last (`last_gnt`).
  - On a grant, latch the grantee's `we`, `addr` and `wdata` into the memory-side registers, load `cnt` with LAT-1, update `last_gnt`, and go to ACCESS.
- **ACCESS**
  - `m_en`=1; `m_we`, `m_addr` and `m_wdata` are driven from the latched registers and held stable.
  - When `cnt`≠0, decrement `cnt`.
  - When `cnt`=0 on a read, capture `m_rdata` into the grantee's rdata register; then go to RESP.
- **RESP**
  - The grantee's ack is 1 for exactly one cycle; `m_en`=0.
  - Requests are ignored in this state. Always go to IDLE.
- Read-data registers change only on read completions. Writes leave `p_rdata` and `d_rdata` unchanged.
- Requester rule: hold `req`, `we`, `addr` and `wdata` stable until ack. After ack, the requester may keep `req` high to request another access.
- If a requester drops `req` mid-transaction, the transaction still completes and the ack still pulses. The requester ignores that ack.
- Inputs of the non-granted port are not sampled while a transaction is in flight.
- `cnt` is 3 bits wide. LAT=0 is illegal; the design is not required to handle it.

## Timing
- Reset values: state=IDLE, `m_en`=0, `m_we`=0, `m_addr`=0, `m_wdata`=0, `p_ack`=0, `d_ack`=0, `p_rdata`=0, `d_rdata`=0, `cnt`=0.
- Reset sets `last_gnt`=D, so P wins the first contention.
- Reset asserted mid-transaction:
  - All outputs go to their reset values immediately (asynchronous).
  - No ack is issued for the aborted transaction.
- Latency: request sampled in IDLE cycle n → `m_en` high in cycles n+1..n+LAT → ack in cycle n+LAT+1.
- Throughput: back-to-back transactions repeat every LAT+2 cycles.
- Contention: with both ports requesting continuously, grants strictly alternate P, D, P, D.
- `stall` is high from the cycle `p_req` rises through the cycle before `p_ack`.
- `stall` is low in the `p_ack` cycle.

## Structure
- Shared package `dmem_pkg`:
  - state enum (IDLE, ACCESS, RESP);
  - port-id constants `PORT_P`=0 and `PORT_D`=1;
  - `LAT_MAX`=7.
- One sub-module, `dmem_rr_pick`: a combinational 2-way round-robin chooser.
  - Inputs: `p_req`, `d_req`, `last_gnt`.
  - Outputs: `grant_valid`, `grant_id`.
- The counter and FSM live in `dmem_arbiter`.

## Test plan
- **Reset:** drive `reset_n`=0 with random inputs → all outputs 0 and `stall` = `p_req`. Release reset, then contend → P granted first.
- **Single read (LAT=1):** memory holds 0xA5 at 0x10; `p_req` with read of 0x10 in cycle 0 → `m_en` in cycle 1, `p_ack` in cycle 2 with `p_rdata`=0xA5, `stall`=1 in cycles 0–1, and `d_rdata` unchanged.
- **Contended writes (LAT=1):** P writes 0x11 to 0x20 and D writes 0x22 to 0x21, both in cycle 0 → `p_ack` in cycle 2, D granted in cycle 3, `d_ack` in cycle 5. Memory then holds 0x11@0x20 and 0x22@0x21.
- **Continuous contention:** both ports request for 4 transactions → ack order P, D, P, D, with period 3 cycles (LAT=1).
- **Latency (LAT=3):** P read → `m_en` high for exactly 3 cycles, `p_ack` in cycle 4, `m_addr` stable throughout.
- **Reset during ACCESS:** reset while `m_en`=1 → `m_en` drops without waiting for a clock and no ack appears. After release, a pending P request restarts from IDLE with full latency.
